// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO between the UART receiver and a byte consumer.
// Occupancy count, sticky overflow/underflow flags, synchronous clear.
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop_data = mem[rd_ptr];

    // A pop frees the slot a same-cycle push needs when the FIFO is full.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push && full && !pop_ok) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Randomized scoreboard bench for uart_byte_fifo against a queue model.
// Popped bytes are checked by an independent negedge monitor.
module tb_uart_byte_fifo;

    localparam int DEPTH = 16;
    localparam int AW = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          push = 1'b0;
    logic [7:0]    push_data = 8'h00;
    logic          pop = 1'b0;
    logic [7:0]    pop_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq [$];
    logic [7:0] exp_q [$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    uart_byte_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .push(push),
        .push_data(push_data),
        .pop(pop),
        .pop_data(pop_data),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: every byte the consumer takes must be the next expected one.
    always @(negedge clk) begin
        if (!rst && pop && !empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", pop_data);
            end else begin
                chk("pop_data", {24'd0, pop_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_state();
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
        chk("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("underflow", {31'd0, underflow}, {31'd0, m_unf});
        if (mq.size() > 0) begin
            chk("head", {24'd0, pop_data}, {24'd0, mq[0]});
        end
    endtask

    // One clock of stimulus; the model applies the FIFO rules to its queue.
    task automatic cycle(input bit p, input logic [7:0] d, input bit q,
                         input bit c);
        bit pa;
        bit qa;
        push = p;
        push_data = d;
        pop = q;
        clear = c;
        qa = q && mq.size() > 0;
        pa = p && (mq.size() < DEPTH || qa);
        if (qa) begin
            exp_q.push_back(mq[0]);
        end
        @(posedge clk);
        #1;
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (p && mq.size() == DEPTH && !qa) m_ovf = 1'b1;
            if (q && mq.size() == 0) m_unf = 1'b1;
            if (qa) void'(mq.pop_front());
            if (pa) mq.push_back(d);
        end
        push = 1'b0;
        pop = 1'b0;
        clear = 1'b0;
        check_state();
    endtask

    initial begin
        logic [7:0] nxt;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(0, 8'h00, 0, 0);

        cycle(1, 8'hA5, 0, 0);
        chk("first_head", {24'd0, pop_data}, 32'hA5);
        cycle(1, 8'h3C, 0, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);

        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0);
        cycle(1, 8'hFF, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 1);

        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h80 + i), 0, 0);
        cycle(1, 8'h55, 1, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);

        cycle(0, 8'h00, 1, 0);
        cycle(1, 8'h77, 1, 0);
        chk("pushpop_empty_head", {24'd0, pop_data}, 32'h77);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 1);

        nxt = 8'h10;
        cycle(1, nxt, 0, 0);
        nxt++;
        for (int i = 0; i < 40; i++) begin
            bit p;
            bit q;
            p = $urandom_range(0, 1) == 1;
            q = $urandom_range(0, 1) == 1;
            if (mq.size() == 1) q = 1'b0;
            if (mq.size() == 5) p = 1'b0;
            cycle(p, nxt, q, 0);
            if (p) nxt++;
        end
        while (mq.size() > 0) cycle(0, 8'h00, 1, 0);

        for (int i = 0; i < 3; i++) cycle(1, 8'(8'hC0 + i), 0, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(1, 8'hEE, 0, 1);
        cycle(1, 8'h42, 0, 0);
        chk("after_clear_head", {24'd0, pop_data}, 32'h42);

        for (int i = 0; i < 400; i++) begin
            bit c;
            c = $urandom_range(0, 49) == 0;
            cycle($urandom_range(0, 2) != 0, 8'($urandom),
                  !c && $urandom_range(0, 2) == 0, c);
        end

        for (int i = 0; i < 4; i++) cycle(1, 8'($urandom), 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(0, 8'h00, 0, 0);
        cycle(1, 8'h9A, 0, 0);
        cycle(0, 8'h00, 1, 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_byte_fifo.md
Name: uart_byte_fifo

Overview:
- Byte FIFO between the UART receiver and the UART transmitter (or any byte consumer).
- Absorbs bursts of received bytes: the write side is driven by the receiver's one-cycle done strobe and data byte; the read side feeds the transmitter's start/data inputs.
- Show-ahead (first-word-fall-through) read port, occupancy count, sticky overflow/underflow flags, synchronous clear.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, at least 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-high reset
- clear  input  1  synchronous flush; empties FIFO and clears flags
- push  input  1  write strobe, one byte per cycle when high
- push_data  input  8  byte written on push
- pop  input  1  read-acknowledge; removes the head entry
- pop_data  output  8  head entry (show-ahead), valid while empty=0
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  AW+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: push attempted while full without an accepted pop
- underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, underflow=0. Storage array not reset; pop_data is don't-care while empty.
- Storage: DEPTH x 8 register array. wr_ptr and rd_ptr are AW bits and wrap naturally modulo DEPTH. count is a separate AW+1-bit register.
- full, empty and count are registered state, or decoded combinationally from count only; no dependence on same-cycle push/pop.
- pop_data = mem[rd_ptr], combinational read. The head byte is visible the cycle after the push that made empty fall: zero-cycle show-ahead, one-cycle push-to-visible latency.
- Accepted push (push=1 and (full=0 or accepted pop this cycle)): mem[wr_ptr] <= push_data; wr_ptr increments.
- Accepted pop (pop=1 and empty=0): rd_ptr increments. The consumer samples pop_data in the same cycle it asserts pop.
- count update: +1 on accepted push only; -1 on accepted pop only; unchanged when both or neither are accepted.
- Simultaneous push+pop:
  - empty=1: push accepted, pop rejected; underflow sets; count becomes 1.
  - full=1: both accepted; count stays DEPTH; overflow does not set.
  - otherwise: both accepted; count unchanged.
- Push while full without pop: byte dropped; pointers and count unchanged; overflow <= 1.
- Pop while empty: no state change except underflow <= 1.
- Flags are sticky until clear or rst.
- clear=1 has priority over push and pop in the same cycle: pointers=0, count=0, overflow=0, underflow=0; the push is discarded.
- Wrap-around: after DEPTH accepted pushes and pops, pointers return to 0 with data order preserved (strict FIFO order at all times).
- Intended loopback use: push=rx_done, push_data=rx_data; the consumer issues pop together with tx_start when empty=0 and the transmitter is idle.

Test Plan:
- Reset then idle → empty=1, full=0, count=0, overflow=0, underflow=0.
- Push 0xA5, then push 0x3C on consecutive cycles:
  - cycle after the first push: pop_data=0xA5, count=1;
  - pop twice → 0xA5 then 0x3C read in order, empty=1 afterward.
- Push 16 bytes 0x00..0x0F → full=1, count=16. Push 0xFF with pop=0 → overflow=1, count=16. Drain 16 pops → reads 0x00..0x0F (0xFF absent).
- With full=1: push 0x55 and pop in the same cycle → count stays 16, overflow stays 0, popped byte is the head; 0x55 emerges last after draining.
- With empty=1: assert pop alone → underflow=1, count=0. Then push 0x77 with pop in the same cycle → count=1, pop_data=0x77.
- Wrap and control:
  - Run 40 interleaved pushes/pops (0x10.., occupancy kept 1..5) → strict ordering across pointer wrap.
  - clear with push=1 → count=0, empty=1, flags=0, pushed byte discarded.
  - rst asserted mid-stream → immediate empty=1, count=0.
